// File: rtl/tile_color_mapper.sv
// Three-stage pixel colour mapper for the 2048 board: board/highlight storage plus RGB lookup.
// Optional TILE_BORDER_EN halves the palette on the one-pixel outline of non-empty tiles.
module tile_color_mapper #(
  parameter int GRID_N        = 4,
  parameter int PITCH_LOG2    = 6,
  parameter int TILE_W        = 56,
  parameter int ORIGIN_X      = 192,
  parameter int ORIGIN_Y      = 112,
  parameter int HILITE_FRAMES = 8
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      pix_in_valid,
  input  logic                      frame_start,
  input  logic                      wr_en,
  input  logic [$clog2(GRID_N)-1:0] wr_row,
  input  logic [$clog2(GRID_N)-1:0] wr_col,
  input  logic [3:0]                wr_val,
  input  logic                      wr_spawn,
  output logic [7:0]                Red,
  output logic [7:0]                Green,
  output logic [7:0]                Blue,
  output logic                      pix_out_valid
);

  localparam int IDX_W  = $clog2(GRID_N);
  localparam int CELLS  = GRID_N * GRID_N;
  localparam int CELL_W = $clog2(CELLS);
  localparam int HL_W   = $clog2(HILITE_FRAMES + 1);
  localparam int LO_W   = PITCH_LOG2 + IDX_W;

  localparam logic signed [10:0]  ORG_X   = 11'(ORIGIN_X);
  localparam logic signed [10:0]  ORG_Y   = 11'(ORIGIN_Y);
  localparam logic signed [10:0]  SPAN    = 11'(GRID_N << PITCH_LOG2);
  localparam logic [PITCH_LOG2-1:0] TW      = PITCH_LOG2'(TILE_W);
  localparam logic [PITCH_LOG2-1:0] TW_LAST = PITCH_LOG2'(TILE_W - 1);
  localparam logic [IDX_W:0]      GN      = (IDX_W + 1)'(GRID_N);
  localparam logic [HL_W-1:0]     HL_LOAD = HL_W'(HILITE_FRAMES);

  localparam logic [23:0] BG_RGB  = 24'hFAF8EF;
  localparam logic [23:0] GAP_RGB = 24'hBBADA0;

`ifdef TILE_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  function automatic logic [23:0] palette(input logic [3:0] e);
    case (e)
      4'd0:    palette = 24'hCDC1B4;
      4'd1:    palette = 24'hEEE4DA;
      4'd2:    palette = 24'hEDE0C8;
      4'd3:    palette = 24'hF2B179;
      4'd4:    palette = 24'hF59563;
      4'd5:    palette = 24'hF67C5F;
      4'd6:    palette = 24'hF65E3B;
      4'd7:    palette = 24'hEDCF72;
      4'd8:    palette = 24'hEDCC61;
      4'd9:    palette = 24'hEDC850;
      4'd10:   palette = 24'hEDC53F;
      4'd11:   palette = 24'hEDC22E;
      default: palette = 24'h3C3A32;
    endcase
  endfunction

  function automatic logic [7:0] brighten(input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, c} + 9'h040;
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [3:0]      board [CELLS];
  logic [HL_W-1:0] hl    [CELLS];

  logic signed [10:0] dx_c, dy_c;
  logic               on_board_c;

  logic            s1_valid, s1_on_board;
  logic [LO_W-1:0] s1_dx, s1_dy;

  logic [PITCH_LOG2-1:0] ox, oy;
  logic [IDX_W-1:0]      rd_row, rd_col;
  logic [CELL_W-1:0]     rd_cell, wr_cell;
  logic                  rd_ok, wr_ok;

  logic       s2_valid, s2_on_board, s2_in_tile, s2_edge, s2_hilite;
  logic [3:0] s2_exp;

  logic [23:0] tile_c, rgb_c;

  assign dx_c = $signed({1'b0, DrawX}) - ORG_X;
  assign dy_c = $signed({1'b0, DrawY}) - ORG_Y;
  assign on_board_c = !dx_c[10] && !dy_c[10] && (dx_c < SPAN) && (dy_c < SPAN);

  // Stage 1: board-relative offsets; only the bits that can address a tile are kept.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_on_board <= 1'b0;
      s1_dx       <= '0;
      s1_dy       <= '0;
    end else begin
      s1_valid    <= pix_in_valid;
      s1_on_board <= on_board_c;
      s1_dx       <= dx_c[LO_W-1:0];
      s1_dy       <= dy_c[LO_W-1:0];
    end
  end

  assign ox      = s1_dx[PITCH_LOG2-1:0];
  assign oy      = s1_dy[PITCH_LOG2-1:0];
  assign rd_col  = s1_dx[LO_W-1:PITCH_LOG2];
  assign rd_row  = s1_dy[LO_W-1:PITCH_LOG2];
  assign rd_ok   = ({1'b0, rd_row} < GN) && ({1'b0, rd_col} < GN);
  assign rd_cell = CELL_W'(int'(rd_row) * GRID_N + int'(rd_col));
  assign wr_ok   = wr_en && ({1'b0, wr_row} < GN) && ({1'b0, wr_col} < GN);
  assign wr_cell = CELL_W'(int'(wr_row) * GRID_N + int'(wr_col));

  // A write beats a same-cycle frame decrement on its own tile; other tiles still decay.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < CELLS; i++) begin
        board[CELL_W'(i)] <= '0;
        hl[CELL_W'(i)]    <= '0;
      end
    end else begin
      for (int i = 0; i < CELLS; i++) begin
        if (wr_ok && wr_cell == CELL_W'(i)) begin
          board[CELL_W'(i)] <= wr_val;
          hl[CELL_W'(i)]    <= (wr_spawn && wr_val != 4'd0) ? HL_LOAD : '0;
        end else if (frame_start && hl[CELL_W'(i)] != '0) begin
          hl[CELL_W'(i)] <= hl[CELL_W'(i)] - HL_W'(1);
        end
      end
    end
  end

  // Stage 2: tile lookup; sampling at the write edge naturally yields the pre-write value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid    <= 1'b0;
      s2_on_board <= 1'b0;
      s2_in_tile  <= 1'b0;
      s2_edge     <= 1'b0;
      s2_exp      <= '0;
      s2_hilite   <= 1'b0;
    end else begin
      s2_valid    <= s1_valid;
      s2_on_board <= s1_on_board;
      s2_in_tile  <= (ox < TW) && (oy < TW);
      s2_edge     <= (ox == '0) || (ox == TW_LAST) || (oy == '0) || (oy == TW_LAST);
      s2_exp      <= rd_ok ? board[rd_cell] : 4'd0;
      s2_hilite   <= rd_ok ? (hl[rd_cell] != '0) : 1'b0;
    end
  end

  always_comb begin
    tile_c = palette(s2_exp);
    if (s2_hilite && s2_exp != 4'd0)
      tile_c = {brighten(tile_c[23:16]), brighten(tile_c[15:8]), brighten(tile_c[7:0])};
    if (BORDER_EN && s2_edge && s2_exp != 4'd0)
      tile_c = {1'b0, tile_c[23:17], 1'b0, tile_c[15:9], 1'b0, tile_c[7:1]};
    if (!s2_on_board)
      rgb_c = BG_RGB;
    else if (!s2_in_tile)
      rgb_c = GAP_RGB;
    else
      rgb_c = tile_c;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red           <= '0;
      Green         <= '0;
      Blue          <= '0;
      pix_out_valid <= 1'b0;
    end else begin
      Red           <= rgb_c[23:16];
      Green         <= rgb_c[15:8];
      Blue          <= rgb_c[7:0];
      pix_out_valid <= s2_valid;
    end
  end

endmodule

// File: tb/tb_tile_color_mapper.sv
// Scoreboard bench for tile_color_mapper: directed board scenarios followed by random traffic
// checked against an arithmetic model of the board, highlight timers and colour rules.
module tb_tile_color_mapper;

  localparam int GRID_N = 4;
  localparam int PITCH  = 64;
  localparam int TILE_W = 56;
  localparam int OX     = 192;
  localparam int OY     = 112;
  localparam int HL_FR  = 8;

`ifdef TILE_BORDER_EN
  localparam logic [23:0] ORIGIN_TILE_RGB = 24'h77726D;
`else
  localparam logic [23:0] ORIGIN_TILE_RGB = 24'hEEE4DA;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       pix_in_valid = 1'b0, frame_start = 1'b0, wr_en = 1'b0, wr_spawn = 1'b0;
  logic [1:0] wr_row = '0, wr_col = '0;
  logic [3:0] wr_val = '0;
  logic [7:0] Red, Green, Blue;
  logic       pix_out_valid;

  tile_color_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .pix_in_valid(pix_in_valid), .frame_start(frame_start), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val), .wr_spawn(wr_spawn),
    .Red(Red), .Green(Green), .Blue(Blue), .pix_out_valid(pix_out_valid)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [23:0] rgb;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Reference state: tile exponents and remaining highlight frames.
  int bm [GRID_N][GRID_N];
  int hm [GRID_N][GRID_N];
  logic [23:0] pal [16] = '{24'hCDC1B4, 24'hEEE4DA, 24'hEDE0C8, 24'hF2B179,
                            24'hF59563, 24'hF67C5F, 24'hF65E3B, 24'hEDCF72,
                            24'hEDCC61, 24'hEDC850, 24'hEDC53F, 24'hEDC22E,
                            24'h3C3A32, 24'h3C3A32, 24'h3C3A32, 24'h3C3A32};

  function automatic logic [23:0] model_rgb(input int x, input int y);
    int dx, dy, ox, oy, e;
    int ch[3];
    logic [23:0] c;
    dx = x - OX;
    dy = y - OY;
    if (dx < 0 || dy < 0 || dx >= GRID_N * PITCH || dy >= GRID_N * PITCH) return 24'hFAF8EF;
    ox = dx % PITCH;
    oy = dy % PITCH;
    if (ox >= TILE_W || oy >= TILE_W) return 24'hBBADA0;
    e = bm[dy / PITCH][dx / PITCH];
    c = pal[e];
    ch[0] = int'(c[23:16]);
    ch[1] = int'(c[15:8]);
    ch[2] = int'(c[7:0]);
    for (int k = 0; k < 3; k++) begin
      if (hm[dy / PITCH][dx / PITCH] > 0 && e != 0) ch[k] = (ch[k] + 64 > 255) ? 255 : ch[k] + 64;
`ifdef TILE_BORDER_EN
      if (e != 0 && (ox == 0 || oy == 0 || ox == TILE_W - 1 || oy == TILE_W - 1)) ch[k] = ch[k] / 2;
`endif
    end
    return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < GRID_N; r++)
      for (int c = 0; c < GRID_N; c++) begin
        bm[r][c] = 0;
        hm[r][c] = 0;
      end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the expected colour is queued from the board state the pixel will see.
  task automatic applyStimulus(input logic v, input int x, input int y,
                               input logic we, input int r, input int c, input int val,
                               input logic sp, input logic fs,
                               input logic use_gold, input logic [23:0] gold);
    exp_t e;
    @(negedge Clk);
    pix_in_valid = v;
    DrawX        = 10'(x);
    DrawY        = 10'(y);
    wr_en        = we;
    wr_row       = 2'(r);
    wr_col       = 2'(c);
    wr_val       = 4'(val);
    wr_spawn     = sp;
    frame_start  = fs;
    @(posedge Clk);
    #1;
    for (int i = 0; i < GRID_N; i++)
      for (int j = 0; j < GRID_N; j++) begin
        if (we && r == i && c == j) begin
          bm[i][j] = val;
          hm[i][j] = (sp && val != 0) ? HL_FR : 0;
        end else if (fs && hm[i][j] > 0) begin
          hm[i][j] = hm[i][j] - 1;
        end
      end
    if (v) begin
      e.rgb = use_gold ? gold : model_rgb(x, y);
      e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] gold);
    applyStimulus(1'b1, x, y, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, gold);
  endtask

  task automatic wr(input int r, input int c, input int val, input logic sp, input logic fs);
    applyStimulus(1'b0, 0, 0, 1'b1, r, c, val, sp, fs, 1'b0, 24'h0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  // Monitor: every valid output pops the oldest expectation; overdue expectations are failures.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n) begin
      if (pix_out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'(pix_out_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          checkOutput("rgb", {8'h0, Red, Green, Blue}, {8'h0, e.rgb});
          checkOutput("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end else if (sb.size() > 0 && cyc - sb[0].cyc > 2) begin
        e = sb.pop_front();
        checkOutput("missing_valid", 32'(pix_out_valid), 32'h1);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    checkOutput("reset_valid", 32'(pix_out_valid), 32'h0);
    checkOutput("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
    Reset_n = 1'b1;

    wr(0, 0, 1, 1'b0, 1'b0);
    pix(192, 112, ORIGIN_TILE_RGB);
    pix(193, 113, 24'hEEE4DA);
    pix(250, 112, 24'hBBADA0);
    pix(0, 0, 24'hFAF8EF);
    pix(448, 112, 24'hFAF8EF);
    pix(191, 200, 24'hFAF8EF);

    wr(3, 3, 11, 1'b1, 1'b0);
    pix(436, 356, 24'hFFFF6E);
    frames(7);
    pix(436, 356, 24'hFFFF6E);
    frames(1);
    pix(436, 356, 24'hEDC22E);
    wr(3, 3, 11, 1'b1, 1'b1);
    frames(7);
    pix(436, 356, 24'hFFFF6E);
    frames(1);
    pix(436, 356, 24'hEDC22E);
    frames(1);
    pix(436, 356, 24'hEDC22E);

    pix(330, 186, 24'hCDC1B4);
    applyStimulus(1'b1, 330, 186, 1'b1, 1, 2, 4, 1'b0, 1'b0, 1'b1, 24'hF59563);
    pix(330, 186, 24'hF59563);

    applyStimulus(1'b1, 192, 112, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b1, 250, 300, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b1, 436, 356, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 24'h0);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    pix_in_valid = 1'b0;
    wr_en = 1'b0;
    frame_start = 1'b0;
    #1;
    checkOutput("midreset_valid", 32'(pix_out_valid), 32'h0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    pix(192, 112, 24'hCDC1B4);
    pix(436, 356, 24'hCDC1B4);

    for (int n = 0; n < 3000; n++) begin
      int x, y, r, c, val;
      logic v, we, sp, fs;
      v   = ($urandom_range(0, 3) != 0);
      x   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(180, 460));
      y   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(100, 380));
      we  = ($urandom_range(0, 5) == 0);
      r   = int'($urandom_range(0, GRID_N - 1));
      c   = int'($urandom_range(0, GRID_N - 1));
      val = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
      sp  = ($urandom_range(0, 1) == 1);
      fs  = ($urandom_range(0, 9) == 0);
      applyStimulus(v, x, y, we, r, c, val, sp, fs, 1'b0, 24'h0);
    end

    idle(5);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
